// File: rtl/player_status.sv
// player_status: per-player life/death tracker with a global game-over flag.
// Latency: every output is registered and reacts one clk after the qualifying edge.
// Backpressure: none; frame_tick_i is a strobe and each cycle it is high gets evaluated.
//
// Optional feature macro: PLAYER_GRACE_EN
//   defined   -> GRACE state with a frame-tick countdown after restart and after a non-fatal hit
//   undefined -> no GRACE state, no counter, in_grace_o tied low, restart lands in ALIVE
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   frame_tick_i   one-cycle pulse per video frame; out-of-bounds evaluation strobe
//   restart_i      one-cycle pulse; starts a new game on every enabled channel
//   player_en_i    per-player enable; low forces the channel to DEAD with zero lives
//   height_i       packed top heights, player i at [i*HEIGHT_W +: HEIGHT_W]
//   lives_o        packed remaining lives, player i at [i*3 +: 3]
//   is_dead_o      1 = player dead or disabled
//   in_grace_o     1 = player currently invulnerable
//   hit_pulse_o    one-cycle pulse for every registered hit
//   game_over_o    1 = every channel is dead
module player_status #(
    parameter int N_PLAYERS    = 2,
    parameter int HEIGHT_W     = 9,
    parameter int TOP_LIMIT    = 10,
    parameter int BOTTOM_LIMIT = 420,
    parameter int LIVES        = 3,
    parameter int GRACE_FRAMES = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            frame_tick_i,
    input  logic                            restart_i,
    input  logic [N_PLAYERS-1:0]            player_en_i,
    input  logic [N_PLAYERS*HEIGHT_W-1:0]   height_i,
    output logic [N_PLAYERS*3-1:0]          lives_o,
    output logic [N_PLAYERS-1:0]            is_dead_o,
    output logic [N_PLAYERS-1:0]            in_grace_o,
    output logic [N_PLAYERS-1:0]            hit_pulse_o,
    output logic                            game_over_o
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------
    if (N_PLAYERS < 1 || N_PLAYERS > 8) begin : g_chk_players
        $error("player_status: N_PLAYERS must be 1..8");
    end
    if (LIVES < 1 || LIVES > 7) begin : g_chk_lives
        $error("player_status: LIVES must be 1..7");
    end
    if (GRACE_FRAMES < 1) begin : g_chk_grace
        $error("player_status: GRACE_FRAMES must be >= 1");
    end

    // Limits narrowed to the height bus so the compare is a plain unsigned
    // compare at the bus width.
    localparam logic [HEIGHT_W-1:0] TOP_H      = HEIGHT_W'(TOP_LIMIT);
    localparam logic [HEIGHT_W-1:0] BOTTOM_H   = HEIGHT_W'(BOTTOM_LIMIT);
    localparam logic [2:0]          LIVES_INIT = 3'(LIVES);

`ifdef PLAYER_GRACE_EN
    localparam int              CNT_W    = $clog2(GRACE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(GRACE_FRAMES);

    typedef enum logic [1:0] {
        ST_DEAD  = 2'd0,
        ST_ALIVE = 2'd1,
        ST_GRACE = 2'd2
    } state_e;
`else
    typedef enum logic [0:0] {
        ST_DEAD  = 1'b0,
        ST_ALIVE = 1'b1
    } state_e;
`endif

    // ------------------------------------------------------------------
    // Per-channel state
    // ------------------------------------------------------------------
    state_e     state_q [N_PLAYERS];
    state_e     state_d [N_PLAYERS];
    logic [2:0] lives_q [N_PLAYERS];
    logic [2:0] lives_d [N_PLAYERS];
    logic       hit_q   [N_PLAYERS];
    logic       hit_d   [N_PLAYERS];
`ifdef PLAYER_GRACE_EN
    logic [CNT_W-1:0] cnt_q [N_PLAYERS];
    logic [CNT_W-1:0] cnt_d [N_PLAYERS];
`endif

    logic                 oob      [N_PLAYERS];
    logic [N_PLAYERS-1:0] dead_nxt;
    logic                 game_over_q;

    // Out-of-bounds detect per channel.
    always_comb begin
        for (int i = 0; i < N_PLAYERS; i++) begin
            oob[i] = (height_i[i*HEIGHT_W +: HEIGHT_W] < TOP_H) ||
                     (height_i[i*HEIGHT_W +: HEIGHT_W] > BOTTOM_H);
        end
    end

    // ------------------------------------------------------------------
    // Process 1: state registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_PLAYERS; i++) begin
                state_q[i] <= ST_DEAD;
                lives_q[i] <= 3'd0;
                hit_q[i]   <= 1'b0;
`ifdef PLAYER_GRACE_EN
                cnt_q[i]   <= '0;
`endif
            end
            // Every channel starts dead, so the game is over out of reset.
            game_over_q <= 1'b1;
        end else begin
            for (int i = 0; i < N_PLAYERS; i++) begin
                state_q[i] <= state_d[i];
                lives_q[i] <= lives_d[i];
                hit_q[i]   <= hit_d[i];
`ifdef PLAYER_GRACE_EN
                cnt_q[i]   <= cnt_d[i];
`endif
            end
            // Taken from next-state so it moves in the same cycle as is_dead_o.
            game_over_q <= &dead_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Process 2: next-state logic
    // Priority: player_en low, then restart, then frame_tick evaluation.
    // ------------------------------------------------------------------
    always_comb begin
        dead_nxt = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            state_d[i] = state_q[i];
            lives_d[i] = lives_q[i];
            hit_d[i]   = 1'b0;
`ifdef PLAYER_GRACE_EN
            cnt_d[i]   = cnt_q[i];
`endif
            if (!player_en_i[i]) begin
                // Disabled channels are parked in DEAD immediately, no tick needed.
                state_d[i] = ST_DEAD;
                lives_d[i] = 3'd0;
`ifdef PLAYER_GRACE_EN
                cnt_d[i]   = '0;
`endif
            end else if (restart_i) begin
                // A coincident frame_tick is dropped here on purpose.
                lives_d[i] = LIVES_INIT;
`ifdef PLAYER_GRACE_EN
                state_d[i] = ST_GRACE;
                cnt_d[i]   = CNT_INIT;
`else
                state_d[i] = ST_ALIVE;
`endif
            end else if (frame_tick_i) begin
                case (state_q[i])
                    ST_ALIVE: begin
                        if (oob[i]) begin
                            hit_d[i] = 1'b1;
                            if (lives_q[i] <= 3'd1) begin
                                state_d[i] = ST_DEAD;
                                lives_d[i] = 3'd0;
                            end else begin
                                lives_d[i] = lives_q[i] - 3'd1;
`ifdef PLAYER_GRACE_EN
                                state_d[i] = ST_GRACE;
                                cnt_d[i]   = CNT_INIT;
`endif
                                // Without grace the channel stays ALIVE and a
                                // persistent oob costs one life per tick.
                            end
                        end
                    end
`ifdef PLAYER_GRACE_EN
                    ST_GRACE: begin
                        // oob is ignored; leaving on the tick that sees 1
                        // makes GRACE last exactly GRACE_FRAMES ticks.
                        if (cnt_q[i] == CNT_W'(1)) begin
                            state_d[i] = ST_ALIVE;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i]   = cnt_q[i] - CNT_W'(1);
                        end
                    end
`endif
                    default: begin
                        // DEAD ignores height; only restart revives it.
                    end
                endcase
            end
            dead_nxt[i] = (state_d[i] == ST_DEAD);
        end
    end

    // ------------------------------------------------------------------
    // Process 3: outputs, decoded from registered state only
    // ------------------------------------------------------------------
    always_comb begin
        lives_o     = '0;
        is_dead_o   = '0;
        in_grace_o  = '0;
        hit_pulse_o = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            lives_o[i*3 +: 3] = lives_q[i];
            is_dead_o[i]      = (state_q[i] == ST_DEAD);
`ifdef PLAYER_GRACE_EN
            in_grace_o[i]     = (state_q[i] == ST_GRACE);
`endif
            hit_pulse_o[i]    = hit_q[i];
        end
    end

    assign game_over_o = game_over_q;

endmodule

// File: tb/tb_player_status.sv
// tb_player_status: directed table-driven bench for player_status (2 players).
// Latency: each vector is applied for one clk and outputs are compared 1 time unit later.
// Backpressure: none; the bench owns every input.
module tb_player_status;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_tick_i;
    logic        restart_i;
    logic [1:0]  player_en_i;
    logic [17:0] height_i;
    logic [5:0]  lives_o;
    logic [1:0]  is_dead_o;
    logic [1:0]  in_grace_o;
    logic [1:0]  hit_pulse_o;
    logic        game_over_o;

    int n_chk  = 0;
    int n_pass = 0;

    player_status #(
        .N_PLAYERS   (2),
        .HEIGHT_W    (9),
        .TOP_LIMIT   (10),
        .BOTTOM_LIMIT(420),
        .LIVES       (3),
        .GRACE_FRAMES(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick_i(frame_tick_i),
        .restart_i   (restart_i),
        .player_en_i (player_en_i),
        .height_i    (height_i),
        .lives_o     (lives_o),
        .is_dead_o   (is_dead_o),
        .in_grace_o  (in_grace_o),
        .hit_pulse_o (hit_pulse_o),
        .game_over_o (game_over_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] en;
        logic       rs;
        logic       tk;
        logic [8:0] h0;
        logic [8:0] h1;
        logic [2:0] l0;
        logic [2:0] l1;
        logic [1:0] dead;
        logic [1:0] grace;
        logic [1:0] hit;
        logic       go;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [1:0] en, input logic rs, input logic tk,
                                input int h0, input int h1, input int l0, input int l1,
                                input logic [1:0] dead, input logic [1:0] grace,
                                input logic [1:0] hit, input logic go);
        vec_t v;
        v.en = en; v.rs = rs; v.tk = tk;
        v.h0 = 9'(h0); v.h1 = 9'(h1);
        v.l0 = 3'(l0); v.l1 = 3'(l1);
        v.dead = dead; v.grace = grace; v.hit = hit; v.go = go;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
    endtask

    task automatic drive(input logic [1:0] en, input logic rs, input logic tk,
                         input logic [8:0] h0, input logic [8:0] h1);
        player_en_i  = en;
        restart_i    = rs;
        frame_tick_i = tk;
        height_i     = {h1, h0};
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_lives"}, 0, 8'(lives_o), 8'h00);
        chk({tag, "_dead"},  0, 8'(is_dead_o), 8'h03);
        chk({tag, "_grace"}, 0, 8'(in_grace_o), 8'h00);
        chk({tag, "_hit"},   0, 8'(hit_pulse_o), 8'h00);
        chk({tag, "_go"},    0, 8'(game_over_o), 8'h01);
    endtask

    int   seq_l   [6];
    logic seq_hit [6];
    logic seq_d0  [6];
    logic [1:0] rs_grace;

    initial begin
        rst_n        = 1'b0;
        frame_tick_i = 1'b0;
        restart_i    = 1'b0;
        player_en_i  = 2'b00;
        height_i     = '0;

`ifdef PLAYER_GRACE_EN
        tbl.push_back(mk(3, 1, 0, 200, 200, 3, 3, 2'b00, 2'b11, 2'b00, 0));
        tbl.push_back(mk(3, 0, 1, 200, 200, 3, 3, 2'b00, 2'b11, 2'b00, 0));
        tbl.push_back(mk(3, 0, 1, 200, 200, 3, 3, 2'b00, 2'b11, 2'b00, 0));
        tbl.push_back(mk(3, 0, 1, 200, 200, 3, 3, 2'b00, 2'b11, 2'b00, 0));
        tbl.push_back(mk(3, 0, 1, 200, 200, 3, 3, 2'b00, 2'b00, 2'b00, 0));
        tbl.push_back(mk(3, 0, 1, 421, 200, 2, 3, 2'b00, 2'b01, 2'b01, 0));
        tbl.push_back(mk(3, 0, 1, 421, 200, 2, 3, 2'b00, 2'b01, 2'b00, 0));
        tbl.push_back(mk(3, 0, 1, 421, 200, 2, 3, 2'b00, 2'b01, 2'b00, 0));
        tbl.push_back(mk(3, 0, 1, 421, 200, 2, 3, 2'b00, 2'b01, 2'b00, 0));
        tbl.push_back(mk(3, 0, 1, 421, 200, 2, 3, 2'b00, 2'b00, 2'b00, 0));
        tbl.push_back(mk(3, 0, 1, 421,  10, 1, 3, 2'b00, 2'b01, 2'b01, 0));
        tbl.push_back(mk(3, 0, 1, 200, 420, 1, 3, 2'b00, 2'b01, 2'b00, 0));
        tbl.push_back(mk(3, 0, 1, 200,   9, 1, 2, 2'b00, 2'b11, 2'b10, 0));
        tbl.push_back(mk(3, 0, 1, 200, 200, 1, 2, 2'b00, 2'b11, 2'b00, 0));
        tbl.push_back(mk(1, 0, 0, 200, 200, 1, 0, 2'b10, 2'b01, 2'b00, 0));
        tbl.push_back(mk(1, 0, 1, 200, 200, 1, 0, 2'b10, 2'b00, 2'b00, 0));
        tbl.push_back(mk(1, 0, 1, 421, 200, 0, 0, 2'b11, 2'b00, 2'b01, 1));
        tbl.push_back(mk(3, 1, 1,   5,   5, 3, 3, 2'b00, 2'b11, 2'b00, 0));
        // Held oob after restart: 4 protected ticks, then a hit.
        seq_l   = '{3, 3, 3, 3, 2, 2};
        seq_hit = '{0, 0, 0, 0, 1, 0};
        seq_d0  = '{0, 0, 0, 0, 0, 0};
        rs_grace = 2'b11;
`else
        tbl.push_back(mk(3, 1, 0, 200, 200, 3, 3, 2'b00, 2'b00, 2'b00, 0));
        tbl.push_back(mk(3, 0, 1, 421, 200, 2, 3, 2'b00, 2'b00, 2'b01, 0));
        tbl.push_back(mk(3, 0, 0, 421, 200, 2, 3, 2'b00, 2'b00, 2'b00, 0));
        tbl.push_back(mk(3, 0, 1,  10, 420, 2, 3, 2'b00, 2'b00, 2'b00, 0));
        tbl.push_back(mk(3, 0, 1,   9, 200, 1, 3, 2'b00, 2'b00, 2'b01, 0));
        tbl.push_back(mk(3, 0, 1,   0, 421, 0, 2, 2'b01, 2'b00, 2'b11, 0));
        tbl.push_back(mk(3, 0, 1, 500, 500, 0, 1, 2'b01, 2'b00, 2'b10, 0));
        tbl.push_back(mk(3, 0, 1, 500, 500, 0, 0, 2'b11, 2'b00, 2'b10, 1));
        tbl.push_back(mk(3, 0, 0, 200, 200, 0, 0, 2'b11, 2'b00, 2'b00, 1));
        tbl.push_back(mk(3, 1, 1,   5,   5, 3, 3, 2'b00, 2'b00, 2'b00, 0));
        tbl.push_back(mk(1, 0, 0, 200, 200, 3, 0, 2'b10, 2'b00, 2'b00, 0));
        tbl.push_back(mk(1, 0, 1, 200,   5, 3, 0, 2'b10, 2'b00, 2'b00, 0));
        tbl.push_back(mk(1, 1, 0, 200, 200, 3, 0, 2'b10, 2'b00, 2'b00, 0));
        tbl.push_back(mk(0, 0, 0, 200, 200, 0, 0, 2'b11, 2'b00, 2'b00, 1));
        // Held oob without grace: one life per tick, then dead.
        seq_l   = '{2, 1, 0, 0, 0, 0};
        seq_hit = '{1, 1, 1, 0, 0, 0};
        seq_d0  = '{0, 0, 1, 1, 1, 1};
        rs_grace = 2'b00;
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;

        // Table
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].en, tbl[i].rs, tbl[i].tk, tbl[i].h0, tbl[i].h1);
            chk("lives0", i, 8'(lives_o[2:0]), 8'(tbl[i].l0));
            chk("lives1", i, 8'(lives_o[5:3]), 8'(tbl[i].l1));
            chk("is_dead", i, 8'(is_dead_o), 8'(tbl[i].dead));
            chk("in_grace", i, 8'(in_grace_o), 8'(tbl[i].grace));
            chk("hit_pulse", i, 8'(hit_pulse_o), 8'(tbl[i].hit));
            chk("game_over", i, 8'(game_over_o), 8'(tbl[i].go));
        end

        // Asynchronous reset in the middle of a game
        drive(2'b11, 1'b1, 1'b0, 9'd200, 9'd200);
        drive(2'b11, 1'b0, 1'b1, 9'd421, 9'd200);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midreset");
        #1;
        rst_n = 1'b1;

        // First restart after reset is honoured
        drive(2'b11, 1'b1, 1'b0, 9'd200, 9'd200);
        chk("rs_lives", 0, 8'(lives_o), 8'h1b);
        chk("rs_dead", 0, 8'(is_dead_o), 8'h00);
        chk("rs_grace", 0, 8'(in_grace_o), 8'(rs_grace));
        chk("rs_go", 0, 8'(game_over_o), 8'h00);

        // frame_tick held high with P0 persistently out of bounds
        for (int k = 0; k < 6; k++) begin
            drive(2'b11, 1'b0, 1'b1, 9'd500, 9'd200);
            chk("hold_lives0", k, 8'(lives_o[2:0]), 8'(seq_l[k]));
            chk("hold_lives1", k, 8'(lives_o[5:3]), 8'h03);
            chk("hold_hit0", k, 8'(hit_pulse_o[0]), 8'(seq_hit[k]));
            chk("hold_dead0", k, 8'(is_dead_o[0]), 8'(seq_d0[k]));
            chk("hold_go", k, 8'(game_over_o), 8'h00);
        end

        frame_tick_i = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
